// File: rtl/hdmi_timing_if.sv
// hdmi_timing_if -- configuration handshake and timing outputs of the HDMI
// timing generator, bundled as one interface.
//   cfg_ready   : transmitter I2C configuration complete (into generator)
//   cfg_err     : I2C configuration failure (into generator)
//   hsync/vsync : sync outputs, polarity set by generator parameters
//   de          : data enable, high during active video
//   x, y        : pixel/line position of the current output cycle
//   line_start  : one-cycle pulse at x=0
//   frame_start : one-cycle pulse at x=0, y=0
//   running     : high while the generator is in RUN or DRAIN
// modport master is the generator side, modport slave the consumer side.
interface hdmi_timing_if;
    logic        cfg_ready;
    logic        cfg_err;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        line_start;
    logic        frame_start;
    logic        running;

    modport master (
        input  cfg_ready, cfg_err,
        output hsync, vsync, de, x, y, line_start, frame_start, running
    );

    modport slave (
        output cfg_ready, cfg_err,
        input  hsync, vsync, de, x, y, line_start, frame_start, running
    );
endinterface

// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen -- video timing generator gated by the HDMI transmitter's
// I2C configuration status.
//   clk   : pixel clock, the only clock
//   reset : synchronous, active-high
//   tif   : hdmi_timing_if.master (cfg_ready/cfg_err in; sync, de, x, y,
//           line_start, frame_start, running out)
// Line layout is active, front porch, sync, back porch; the frame uses the
// same layout in lines. H_TOTAL and V_TOTAL must each be <= 4096.
// All outputs are registered decodes of the (h,v) counters, one cycle behind.
module hdmi_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    hdmi_timing_if.master tif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

    // 13-bit bounds so a sync region ending exactly at 4096 still compares.
    localparam logic [12:0] H_ACT_END  = 13'(H_ACTIVE);
    localparam logic [12:0] H_SYNC_BEG = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] H_SYNC_END = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_ACT_END  = 13'(V_ACTIVE);
    localparam logic [12:0] V_SYNC_BEG = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] V_SYNC_END = 13'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] h_q, h_d;
    logic [11:0] v_q, v_d;

    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic        running_q, running_d;

    logic        h_last, v_last;
    logic [11:0] h_nxt, v_nxt;
    logic        active;
    logic [12:0] h_ext, v_ext;

    assign h_last = (h_q == H_LAST);
    assign v_last = (v_q == V_LAST);
    assign h_nxt  = h_last ? 12'd0 : h_q + 12'd1;
    assign v_nxt  = h_last ? (v_last ? 12'd0 : v_q + 12'd1) : v_q;

    // Next state and counters.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        case (state_q)
            IDLE: begin
                if (tif.cfg_ready) begin
                    state_d = RUN;
                    h_d     = 12'd0;
                    v_d     = 12'd0;
                end
            end
            RUN: begin
                h_d = h_nxt;
                v_d = v_nxt;
                // If configuration drops on the last pixel of a frame, that
                // frame is already complete, so there is nothing to drain.
                if (!tif.cfg_ready)
                    state_d = (h_last && v_last) ? IDLE : DRAIN;
            end
            DRAIN: begin
                // cfg_ready is deliberately ignored here: re-entry to RUN
                // only happens from IDLE.
                h_d = h_nxt;
                v_d = v_nxt;
                if (h_last && v_last)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                h_d     = 12'd0;
                v_d     = 12'd0;
            end
        endcase
        if (tif.cfg_err) begin
            state_d = IDLE;
            h_d     = 12'd0;
            v_d     = 12'd0;
        end
    end

    // Output decode of the current counters; cfg_err forces idle values on
    // the same edge that forces the state to IDLE.
    assign active = (state_q != IDLE) && !tif.cfg_err;
    assign h_ext  = {1'b0, h_q};
    assign v_ext  = {1'b0, v_q};

    always_comb begin
        hsync_d       = ~HS_POL;
        vsync_d       = ~VS_POL;
        de_d          = 1'b0;
        x_d           = 12'd0;
        y_d           = 12'd0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        running_d     = 1'b0;
        if (active) begin
            de_d          = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
            hsync_d       = ((h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END))
                            ? HS_POL : ~HS_POL;
            // v only moves on the h wrap, so vsync changes only at x=0.
            vsync_d       = ((v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END))
                            ? VS_POL : ~VS_POL;
            x_d           = h_q;
            y_d           = v_q;
            line_start_d  = (h_q == 12'd0);
            frame_start_d = (h_q == 12'd0) && (v_q == 12'd0);
            running_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            h_q           <= 12'd0;
            v_q           <= 12'd0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            x_q           <= 12'd0;
            y_q           <= 12'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            running_q     <= running_d;
        end
    end

    assign tif.hsync       = hsync_q;
    assign tif.vsync       = vsync_q;
    assign tif.de          = de_q;
    assign tif.x           = x_q;
    assign tif.y           = y_q;
    assign tif.line_start  = line_start_q;
    assign tif.frame_start = frame_start_q;
    assign tif.running     = running_q;

endmodule

// File: doc/hdmi_timing_gen.md
HDMI_TIMING_GEN -- requirements
Module: hdmi_timing_gen

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  pixel clock; the block's only clock
- reset  in  1  synchronous, active-high reset
- cfg_ready  in  1  HDMI transmitter I2C configuration complete, from the I2C controller
- cfg_err  in  1  I2C configuration failure, from the I2C controller
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable (active video)
- x  out  12  current horizontal position
- y  out  12  current vertical position
- line_start  out  1  one-cycle pulse at h=0
- frame_start  out  1  one-cycle pulse at h=0, v=0
- running  out  1  high while in RUN or DRAIN

Function
REQ-003 H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP SHALL each be <=4096; all widths are 12-bit unsigned.
REQ-004 State machine SHALL have three states: IDLE, RUN, DRAIN.
REQ-005 IDLE->RUN when cfg_ready=1 and cfg_err=0 are sampled on a clk edge; counters h and v are loaded with 0 on that edge.
REQ-006 In RUN and DRAIN, h SHALL increment every cycle and wrap H_TOTAL-1->0; v SHALL increment when h wraps and wrap V_TOTAL-1->0.
REQ-007 RUN->DRAIN when cfg_ready=0 is sampled; DRAIN SHALL finish the current frame and go to IDLE on the edge where h=H_TOTAL-1 and v=V_TOTAL-1.
REQ-008 cfg_err=1 in any state SHALL force IDLE on the next edge, with all outputs at idle values on that same edge; cfg_err takes priority over cfg_ready.
REQ-009 In DRAIN, cfg_ready returning to 1 SHALL NOT resume RUN; re-entry is only from IDLE.
REQ-010 Line layout SHALL be active, front porch, sync, back porch (frame layout identical, in lines).
REQ-011 Outputs SHALL be registered decodes of (h,v), one cycle behind the counters:
- de=(h<H_ACTIVE)&&(v<V_ACTIVE)
- hsync=HS_POL when H_ACTIVE+H_FP<=h<H_ACTIVE+H_FP+H_SYNC, else ~HS_POL
- vsync=VS_POL for full lines where V_ACTIVE+V_FP<=v<V_ACTIVE+V_FP+V_SYNC (changes only at h=0), else ~VS_POL
- x=h, y=v
- line_start=(h==0); frame_start=(h==0&&v==0)
REQ-012 Idle output values: hsync=~HS_POL, vsync=~VS_POL, de=0, x=0, y=0, line_start=0, frame_start=0, running=0.
REQ-013 running SHALL be registered and go high on the same edge as the first decoded output cycle (de=1 at x=0,y=0).

Reset
REQ-014 reset=1 sampled on a clk edge SHALL set state=IDLE, h=v=0 and all outputs to idle values, overriding every other input, including mid-line and mid-DRAIN.
REQ-015 After reset is released, the block SHALL stay in IDLE until REQ-005 is satisfied.

Verification (small parameters: H 4/1/2/1 -> H_TOTAL=8; V 3/1/1/1 -> V_TOTAL=6; 48-cycle frame; HS_POL=VS_POL=0)
REQ-016 reset=1 for 5 cycles with cfg_ready=1 -> hsync=1, vsync=1, de=0, x=y=0, running=0 throughout.
REQ-017 cfg_ready sampled high at edge k -> at edge k+1, de=1, x=0, y=0, frame_start=1, line_start=1, running=1.
REQ-018 Free run for 3 frames -> per line: de high for 4 cycles (x=0..3) on lines y=0..2; hsync=0 exactly at x=5,6; vsync=0 for all 8 cycles of y=4; frame_start every 48 cycles; line_start every 8 cycles.
REQ-019 cfg_ready drops at x=2,y=1 -> counting continues to x=7,y=5, then the next cycle shows idle values with running=0; a further cfg_ready=1 restarts at x=0,y=0.
REQ-020 cfg_err pulsed for 1 cycle at x=3,y=2 with cfg_ready=1 -> idle values on that edge, then a restart from x=0,y=0 one edge later (cfg_ready still high).
REQ-021 reset asserted at x=6,y=4 -> idle values the next edge; after release with cfg_ready=1, the sequence restarts per REQ-017.
